sn_count: RTL and testbench
===========================

Name: sn_count

Overview:
- Stochastic-to-binary converter: the receiving end of the stochastic number generator's dual-rail bitstream (SN_P/SN_N).
- Counts ones on each rail over a programmable window of enabled cycles.
- Returns the unipolar count of the P rail and the signed bipolar difference P−N.
- Sits downstream of the stochastic compute fabric; the host reads results over the same 32-bit register interface style.

Parameters:
- CNT_W, 24, width of window length and per-rail counters; max window 2^CNT_W−1 samples.
- DEFAULT_LEN, 1024, window length loaded at reset.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- EN  in  1  sample enable; one bitstream sample per CLK when high
- DATA_IN  in  32  window-length write data; bits [CNT_W-1:0] used
- LEN_WE  in  1  load window length from DATA_IN
- START  in  1  begin a new counting window (1-cycle pulse)
- SN_IN_P  in  1  positive-rail stochastic bit
- SN_IN_N  in  1  negative-rail stochastic bit
- RESULT_RE  in  1  host acknowledges/consumes result
- BUSY  out  1  high while counting (state RUN)
- DONE  out  1  high while a result is valid and unacknowledged
- RESULT_P  out  32  P-rail ones count, zero-extended
- RESULT  out  32  signed (count_P − count_N), sign-extended two's complement

Behaviour:
- Reset: state IDLE; BUSY=0, DONE=0, RESULT_P=0, RESULT=0; len_reg=DEFAULT_LEN; internal counters 0.
- len_reg:
  - LEN_WE loads DATA_IN[CNT_W-1:0] in IDLE or DONE.
  - LEN_WE is ignored in RUN; the window in progress always uses the length latched at START.
- States: IDLE, RUN, DONE.
- IDLE:
  - START with len_reg≠0 → RUN next cycle; cnt_p=cnt_n=0, remaining=len_reg.
  - START with len_reg=0 → DONE next cycle; RESULT_P=0, RESULT=0.
- RUN:
  - BUSY=1.
  - Cycle with EN=1: cnt_p+=SN_IN_P, cnt_n+=SN_IN_N, remaining−=1.
  - EN=0: all counters hold; window length counts enabled samples only.
  - When EN=1 and remaining=1, the current sample is the last one. Next cycle: state DONE, BUSY=0, DONE=1.
  - On that transition, RESULT_P = cnt_p+SN_IN_P and RESULT = (cnt_p+SN_IN_P) − (cnt_n+SN_IN_N), computed in CNT_W+1 bits signed, then sign-extended.
  - Latency: DONE rises exactly 1 cycle after the last enabled sample.
- DONE:
  - DONE=1; RESULT/RESULT_P stable.
  - RESULT_RE → IDLE; DONE=0 next cycle. RESULT/RESULT_P keep their values until the next window completes.
- Arithmetic: counts never exceed len_reg < 2^CNT_W, so no overflow. RESULT range is ±len_reg. Both rails high in the same cycle contribute 0 to RESULT and +1 to RESULT_P.
- Boundary and simultaneous events:
  - START during RUN aborts the window and restarts it (counters cleared, remaining=len_reg); the sample in that cycle is discarded.
  - START and RESULT_RE in the same cycle in DONE: START wins → RUN, DONE=0 next cycle.
  - START and LEN_WE in the same cycle in IDLE/DONE: the new length is used by this window.
  - RESULT_RE outside DONE: ignored.
  - SN_IN_* while not in RUN: ignored.
  - RST in any state, including mid-window: immediate return to reset values on the next edge; takes priority over all inputs.

Test Plan:
- Reset, LEN_WE with DATA_IN=8, START, EN=1 for 8 cycles, SN_IN_P=1 and SN_IN_N=0 every cycle → DONE 1 cycle after the 8th sample; RESULT_P=8, RESULT=8; BUSY high exactly 8 cycles.
- len=16, EN=1, P pattern 1010…, N=1 on every 4th sample → RESULT_P=8, RESULT=8−4=4; then RESULT_RE → DONE=0 next cycle, RESULT still 4.
- len=4, P=0 and N=1 on all samples → RESULT=0xFFFFFFFC (−4), RESULT_P=0.
- len=4, EN toggled 1,0,0,1,1,0,1 with P=1 → DONE only after the 4th enabled sample (cycle 8), RESULT_P=4.
- Mid-RUN after 3 samples: START pulse then 4 samples with P=1 (len=4) → RESULT_P=4, not 7. Separately, mid-RUN RST → BUSY=0, DONE=0, RESULT=0, len_reg=1024.
- len=0, START → DONE next cycle with RESULT=0. In DONE, START+RESULT_RE together → RUN. LEN_WE during RUN → window length unchanged.

Source files
------------

// File: rtl/sn_count.sv
// sn_count: stochastic-to-binary converter for a dual-rail (P/N) bitstream.
// Counts ones on each rail over a programmable window of enabled samples and
// reports the unipolar P count plus the signed bipolar difference P-N.
module sn_count #(
    parameter int CNT_W       = 24,
    parameter int DEFAULT_LEN = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [31:0] DATA_IN,
    input  logic        LEN_WE,
    input  logic        START,
    input  logic        SN_IN_P,
    input  logic        SN_IN_N,
    input  logic        RESULT_RE,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT_P,
    output logic [31:0] RESULT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt_p;
    logic [CNT_W-1:0] r_cnt_n;
    logic             r_busy;
    logic             r_done;
    logic [31:0]      r_result_p;
    logic [31:0]      r_result;

    logic [CNT_W-1:0] w_sum_p;
    logic [CNT_W-1:0] w_sum_n;
    logic [CNT_W:0]   w_diff;
    logic [CNT_W-1:0] w_start_len;
    logic             w_unused_data;

    // Upper write-data bits carry no meaning for the window length.
    assign w_unused_data = ^DATA_IN[31:CNT_W];

    // Final counts including the current sample, their signed difference,
    // and the length a START in IDLE/DONE would latch (a same-cycle LEN_WE wins).
    always_comb begin
        w_sum_p     = r_cnt_p + {{(CNT_W-1){1'b0}}, SN_IN_P};
        w_sum_n     = r_cnt_n + {{(CNT_W-1){1'b0}}, SN_IN_N};
        w_diff      = {1'b0, w_sum_p} - {1'b0, w_sum_n};
        w_start_len = LEN_WE ? DATA_IN[CNT_W-1:0] : r_len;
    end

    // Window control FSM with counters and registered status/result outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_len      <= CNT_W'(DEFAULT_LEN);
            r_rem      <= {CNT_W{1'b0}};
            r_cnt_p    <= {CNT_W{1'b0}};
            r_cnt_n    <= {CNT_W{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result_p <= 32'd0;
            r_result   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (LEN_WE) begin
                        r_len <= DATA_IN[CNT_W-1:0];
                    end
                    if (START) begin
                        r_cnt_p <= {CNT_W{1'b0}};
                        r_cnt_n <= {CNT_W{1'b0}};
                        r_rem   <= w_start_len;
                        if (w_start_len != {CNT_W{1'b0}}) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end else begin
                            // Empty window completes immediately with zero results.
                            r_state    <= ST_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_result_p <= 32'd0;
                            r_result   <= 32'd0;
                        end
                    end else if ((r_state == ST_DONE) && RESULT_RE) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (START) begin
                        // Abort and restart; this cycle's sample is discarded.
                        r_cnt_p <= {CNT_W{1'b0}};
                        r_cnt_n <= {CNT_W{1'b0}};
                        r_rem   <= r_len;
                    end else if (EN) begin
                        if (r_rem == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            r_state    <= ST_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_rem      <= {CNT_W{1'b0}};
                            r_cnt_p    <= w_sum_p;
                            r_cnt_n    <= w_sum_n;
                            r_result_p <= {{(32-CNT_W){1'b0}}, w_sum_p};
                            r_result   <= {{(32-CNT_W-1){w_diff[CNT_W]}}, w_diff};
                        end else begin
                            r_cnt_p <= w_sum_p;
                            r_cnt_n <= w_sum_n;
                            r_rem   <= r_rem - {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign RESULT_P = r_result_p;
    assign RESULT   = r_result;

endmodule

// File: tb/tb_sn_count.sv
// tb_sn_count: directed-vector bench for sn_count with a window/queue model
// checked every cycle plus hand-computed literal expectations.
module tb_sn_count;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EN = 1'b0;
    logic [31:0] DATA_IN = 32'd0;
    logic        LEN_WE = 1'b0;
    logic        START = 1'b0;
    logic        SN_IN_P = 1'b0;
    logic        SN_IN_N = 1'b0;
    logic        RESULT_RE = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT_P;
    logic [31:0] RESULT;

    int n_tests = 0;
    int n_fail  = 0;

    sn_count #(.CNT_W(24), .DEFAULT_LEN(1024)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .DATA_IN(DATA_IN), .LEN_WE(LEN_WE),
        .START(START), .SN_IN_P(SN_IN_P), .SN_IN_N(SN_IN_N),
        .RESULT_RE(RESULT_RE), .BUSY(BUSY), .DONE(DONE),
        .RESULT_P(RESULT_P), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A window is "open" while collecting samples; it closes when the number
    // of collected samples reaches the length latched at START.
    bit          m_open, m_valid, m_armed;
    int          m_len, m_target;
    bit          qp[$];
    bit          qn[$];
    logic [31:0] m_res_p, m_res;

    always @(posedge CLK) begin
        int new_len;
        int sp, sn;
        if (RST) begin
            m_open = 0; m_valid = 0; m_len = 1024; m_target = 0;
            m_res_p = 32'd0; m_res = 32'd0;
            qp.delete(); qn.delete();
            m_armed = 1;
        end else if (m_armed) begin
            new_len = m_len;
            if (LEN_WE && !m_open) new_len = int'(DATA_IN[23:0]);
            if (START) begin
                m_len = new_len;
                m_target = m_len;
                qp.delete(); qn.delete();
                if (m_target == 0) begin
                    m_open = 0; m_valid = 1; m_res_p = 32'd0; m_res = 32'd0;
                end else begin
                    m_open = 1; m_valid = 0;
                end
            end else if (m_open) begin
                if (EN) begin
                    qp.push_back(SN_IN_P);
                    qn.push_back(SN_IN_N);
                    if (qp.size() == m_target) begin
                        sp = 0; sn = 0;
                        foreach (qp[i]) sp += int'(qp[i]);
                        foreach (qn[i]) sn += int'(qn[i]);
                        m_res_p = 32'(sp);
                        m_res   = 32'(sp - sn);
                        m_open = 0; m_valid = 1;
                    end
                end
            end else begin
                m_len = new_len;
                if (m_valid && RESULT_RE) m_valid = 0;
            end
        end
    end

    // Compare DUT outputs with the model away from the active edge.
    always @(negedge CLK) begin
        if (m_armed) begin
            check("busy", {31'd0, BUSY}, {31'd0, m_open});
            check("done", {31'd0, DONE}, {31'd0, m_valid});
            check("result_p", RESULT_P, m_res_p);
            check("result", RESULT, m_res);
        end
    end

    // One cycle with the given inputs; pulses drop afterwards.
    task automatic drive(input logic st, input logic lw, input logic [31:0] d,
                         input logic en, input logic p, input logic n, input logic re);
        START = st; LEN_WE = lw; DATA_IN = d; EN = en;
        SN_IN_P = p; SN_IN_N = n; RESULT_RE = re;
        @(negedge CLK);
        START = 1'b0; LEN_WE = 1'b0; DATA_IN = 32'd0; EN = 1'b0;
        SN_IN_P = 1'b0; SN_IN_N = 1'b0; RESULT_RE = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        @(negedge CLK);
        do_reset();
        drive(0, 0, 32'd0, 0, 0, 0, 0);
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        check("reset_done", {31'd0, DONE}, 32'd0);
        check("reset_result", RESULT, 32'd0);
        check("reset_result_p", RESULT_P, 32'd0);

        // 1: len=8 (upper DATA_IN bits junk), all P=1
        drive(0, 1, 32'hFF00_0008, 0, 0, 0, 0);
        drive(1, 0, 32'd0, 0, 0, 0, 0);
        busy_cnt = int'(BUSY);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 32'd0, 1, 1, 0, 0);
            if (i < 7) check("t1_no_done_early", {31'd0, DONE}, 32'd0);
            busy_cnt += int'(BUSY);
        end
        check("t1_done", {31'd0, DONE}, 32'd1);
        check("t1_result_p", RESULT_P, 32'd8);
        check("t1_result", RESULT, 32'd8);
        check("t1_busy_cycles", 32'(busy_cnt), 32'd8);
        drive(0, 0, 32'd0, 0, 0, 0, 1);

        // 2: len=16, P=1010..., N on every 4th sample
        drive(0, 1, 32'd16, 0, 0, 0, 0);
        drive(1, 0, 32'd0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) drive(0, 0, 32'd0, 1, (i % 2) == 0, (i % 4) == 3, 0);
        check("t2_done", {31'd0, DONE}, 32'd1);
        check("t2_result_p", RESULT_P, 32'd8);
        check("t2_result", RESULT, 32'd4);
        drive(0, 0, 32'd0, 0, 0, 0, 1);
        check("t2_ack_done", {31'd0, DONE}, 32'd0);
        check("t2_hold_result", RESULT, 32'd4);

        // 3: len=4, N only -> -4
        drive(0, 1, 32'd4, 0, 0, 0, 0);
        drive(1, 0, 32'd0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 32'd0, 1, 0, 1, 0);
        check("t3_result", RESULT, 32'hFFFF_FFFC);
        check("t3_result_p", RESULT_P, 32'd0);
        drive(0, 0, 32'd0, 0, 0, 0, 1);

        // 4: EN gaps 1,0,0,1,1,0,1 with P=1 (len still 4)
        drive(1, 0, 32'd0, 0, 0, 0, 0);
        drive(0, 0, 32'd0, 1, 1, 0, 0);
        drive(0, 0, 32'd0, 0, 1, 0, 0);
        drive(0, 0, 32'd0, 0, 1, 0, 0);
        drive(0, 0, 32'd0, 1, 1, 0, 0);
        drive(0, 0, 32'd0, 1, 1, 0, 0);
        drive(0, 0, 32'd0, 0, 1, 0, 0);
        check("t4_not_yet", {31'd0, DONE}, 32'd0);
        drive(0, 0, 32'd0, 1, 1, 0, 0);
        check("t4_done", {31'd0, DONE}, 32'd1);
        check("t4_result_p", RESULT_P, 32'd4);
        drive(0, 0, 32'd0, 0, 0, 0, 1);

        // 5a: restart mid-window, restart-cycle sample discarded
        drive(1, 0, 32'd0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 32'd0, 1, 1, 0, 0);
        drive(1, 0, 32'd0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 32'd0, 1, 1, 0, 0);
        check("t5_restart_p", RESULT_P, 32'd4);
        drive(0, 0, 32'd0, 0, 0, 0, 1);

        // 5b: reset mid-window restores defaults, len back to 1024
        drive(1, 0, 32'd0, 0, 0, 0, 0);
        drive(0, 0, 32'd0, 1, 1, 0, 0);
        drive(0, 0, 32'd0, 1, 1, 0, 0);
        do_reset();
        check("t5_rst_busy", {31'd0, BUSY}, 32'd0);
        check("t5_rst_result_p", RESULT_P, 32'd0);
        drive(1, 0, 32'd0, 0, 0, 0, 0);
        for (int i = 0; i < 1023; i++) drive(0, 0, 32'd0, 1, 1, 0, 0);
        check("t5_len1024_not_done", {31'd0, DONE}, 32'd0);
        drive(0, 0, 32'd0, 1, 1, 0, 0);
        check("t5_len1024_p", RESULT_P, 32'd1024);

        // 6: len=0 completes immediately with zero results
        drive(0, 1, 32'd0, 0, 0, 0, 0);
        drive(1, 0, 32'd0, 0, 0, 0, 0);
        check("t6_zero_done", {31'd0, DONE}, 32'd1);
        check("t6_zero_result_p", RESULT_P, 32'd0);
        // START + RESULT_RE + LEN_WE(3) in DONE: START wins with new length
        drive(1, 1, 32'd3, 0, 0, 0, 1);
        check("t6_run_busy", {31'd0, BUSY}, 32'd1);
        check("t6_run_done", {31'd0, DONE}, 32'd0);
        drive(0, 1, 32'd10, 1, 1, 1, 0);
        drive(0, 0, 32'd0, 1, 1, 0, 0);
        drive(0, 0, 32'd0, 1, 0, 0, 0);
        check("t6_len_kept_done", {31'd0, DONE}, 32'd1);
        check("t6_len_kept_result", RESULT, 32'd1);
        check("t6_len_kept_p", RESULT_P, 32'd2);
        drive(0, 0, 32'd0, 0, 0, 0, 1);
        drive(0, 0, 32'd0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
